// File: rtl/rob_retire.sv
// ---------------------------------------------------------------------------
// rob_retire
//
// Reorder buffer with an in-order, dual-wide retire engine.
// Dispatch allocates up to two entries per cycle at the tail. Three
// functional units mark entries complete by index. Up to two completed
// entries retire per cycle from the head, in program order. Each retired
// entry returns its stale physical register to the free pool.
//
// Optional build macro:
//   ROB_RETIRE_CHECK_EN - adds a sticky `err` output flagging protocol misuse.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   alloc_valid_1/2              dispatch requests (slot 2 is younger)
//   alloc_rd_1/2                 architectural destination
//   alloc_pd_1/2                 newly mapped physical destination
//   alloc_old_pd_1/2             previous mapping, freed at retire
//   alloc_ready                  at least two entries free
//   alloc_idx_1/2                indices granted to slot 1 / slot 2
//   cmp_valid_0..2, cmp_idx_0..2 completions from FU 0..2
//   ret_valid_1/2                registered retire pulses (slot 1 older)
//   ret_rd_1/2, ret_pd_1/2       retired destination mapping
//   free_valid_1/2, free_pd_1/2  physical register released to free pool
//   err                          sticky misuse flag (ROB_RETIRE_CHECK_EN only)
//   count                        occupied entries, 0..ROB_DEPTH
// ---------------------------------------------------------------------------
module rob_retire #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4,
    parameter int AREG_W    = 5,
    parameter int PREG_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid_1,
    input  logic              alloc_valid_2,
    input  logic [AREG_W-1:0] alloc_rd_1,
    input  logic [AREG_W-1:0] alloc_rd_2,
    input  logic [PREG_W-1:0] alloc_pd_1,
    input  logic [PREG_W-1:0] alloc_pd_2,
    input  logic [PREG_W-1:0] alloc_old_pd_1,
    input  logic [PREG_W-1:0] alloc_old_pd_2,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx_1,
    output logic [IDX_W-1:0]  alloc_idx_2,
    input  logic              cmp_valid_0,
    input  logic              cmp_valid_1,
    input  logic              cmp_valid_2,
    input  logic [IDX_W-1:0]  cmp_idx_0,
    input  logic [IDX_W-1:0]  cmp_idx_1,
    input  logic [IDX_W-1:0]  cmp_idx_2,
    output logic              ret_valid_1,
    output logic              ret_valid_2,
    output logic [AREG_W-1:0] ret_rd_1,
    output logic [AREG_W-1:0] ret_rd_2,
    output logic [PREG_W-1:0] ret_pd_1,
    output logic [PREG_W-1:0] ret_pd_2,
    output logic              free_valid_1,
    output logic              free_valid_2,
    output logic [PREG_W-1:0] free_pd_1,
    output logic [PREG_W-1:0] free_pd_2,
`ifdef ROB_RETIRE_CHECK_EN
    output logic              err,
`endif
    output logic [IDX_W:0]    count
);

    localparam int               CNT_W     = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ROB_DEPTH - 2);

    // Control state
    logic [IDX_W-1:0]     head;
    logic [IDX_W-1:0]     tail;
    logic [CNT_W-1:0]     count_q;
    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] cmpl_q;

    // Payload storage (no reset; only meaningful where valid_q is set)
    logic [AREG_W-1:0] rd_mem     [ROB_DEPTH];
    logic [PREG_W-1:0] pd_mem     [ROB_DEPTH];
    logic [PREG_W-1:0] old_pd_mem [ROB_DEPTH];

    logic [IDX_W-1:0]     head_p1;
    logic [IDX_W-1:0]     tail_p1;
    logic                 do_a1;
    logic                 do_a2;
    logic                 r1;
    logic                 r2;
    logic [CNT_W-1:0]     n_alloc;
    logic [CNT_W-1:0]     n_ret;
    logic [CNT_W-1:0]     count_nxt;
    logic [ROB_DEPTH-1:0] valid_nxt;
    logic [ROB_DEPTH-1:0] cmpl_nxt;

    assign head_p1     = head + IDX_ONE;
    assign tail_p1     = tail + IDX_ONE;
    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail_p1;
    assign count       = count_q;

    // Readiness looks only at registered occupancy; a retire in the same
    // cycle does not make room early.
    assign alloc_ready = (count_q <= READY_MAX);

    // Slot 2 is only honoured behind slot 1 so entries stay contiguous.
    assign do_a1 = alloc_ready && alloc_valid_1;
    assign do_a2 = do_a1 && alloc_valid_2;

    // Second retire requires the first, so nothing passes an incomplete head.
    assign r1 = valid_q[head] && cmpl_q[head];
    assign r2 = r1 && valid_q[head_p1] && cmpl_q[head_p1];

    assign n_alloc   = CNT_W'(do_a1) + CNT_W'(do_a2);
    assign n_ret     = CNT_W'(r1) + CNT_W'(r2);
    assign count_nxt = count_q + n_alloc - n_ret;

    // Ordering matters: completions land first, retire clears override them
    // (completion to a retiring entry is a no-op), and allocations touch only
    // entries that were free before the edge, so they never collide with
    // retiring ones.
    always_comb begin
        valid_nxt = valid_q;
        cmpl_nxt  = cmpl_q;
        if (cmp_valid_0 && valid_q[cmp_idx_0]) cmpl_nxt[cmp_idx_0] = 1'b1;
        if (cmp_valid_1 && valid_q[cmp_idx_1]) cmpl_nxt[cmp_idx_1] = 1'b1;
        if (cmp_valid_2 && valid_q[cmp_idx_2]) cmpl_nxt[cmp_idx_2] = 1'b1;
        if (r1) begin
            valid_nxt[head] = 1'b0;
            cmpl_nxt[head]  = 1'b0;
        end
        if (r2) begin
            valid_nxt[head_p1] = 1'b0;
            cmpl_nxt[head_p1]  = 1'b0;
        end
        if (do_a1) begin
            valid_nxt[tail] = 1'b1;
            cmpl_nxt[tail]  = 1'b0;
        end
        if (do_a2) begin
            valid_nxt[tail_p1] = 1'b1;
            cmpl_nxt[tail_p1]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid_q <= '0;
            cmpl_q  <= '0;
        end else begin
            head    <= head + IDX_W'(n_ret);
            tail    <= tail + IDX_W'(n_alloc);
            count_q <= count_nxt;
            valid_q <= valid_nxt;
            cmpl_q  <= cmpl_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_a1) begin
            rd_mem[tail]     <= alloc_rd_1;
            pd_mem[tail]     <= alloc_pd_1;
            old_pd_mem[tail] <= alloc_old_pd_1;
        end
        if (do_a2) begin
            rd_mem[tail_p1]     <= alloc_rd_2;
            pd_mem[tail_p1]     <= alloc_pd_2;
            old_pd_mem[tail_p1] <= alloc_old_pd_2;
        end
    end

    // Retire output stage: reflects entries retired at the preceding edge.
    // Writes to x0 and zero stale mappings never release a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_1  <= 1'b0;
            ret_valid_2  <= 1'b0;
            ret_rd_1     <= '0;
            ret_rd_2     <= '0;
            ret_pd_1     <= '0;
            ret_pd_2     <= '0;
            free_valid_1 <= 1'b0;
            free_valid_2 <= 1'b0;
            free_pd_1    <= '0;
            free_pd_2    <= '0;
        end else begin
            ret_valid_1  <= r1;
            ret_valid_2  <= r2;
            ret_rd_1     <= r1 ? rd_mem[head]        : '0;
            ret_rd_2     <= r2 ? rd_mem[head_p1]     : '0;
            ret_pd_1     <= r1 ? pd_mem[head]        : '0;
            ret_pd_2     <= r2 ? pd_mem[head_p1]     : '0;
            free_pd_1    <= r1 ? old_pd_mem[head]    : '0;
            free_pd_2    <= r2 ? old_pd_mem[head_p1] : '0;
            free_valid_1 <= r1 && (rd_mem[head] != '0) && (old_pd_mem[head] != '0);
            free_valid_2 <= r2 && (rd_mem[head_p1] != '0) && (old_pd_mem[head_p1] != '0);
        end
    end

`ifdef ROB_RETIRE_CHECK_EN
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        if ((alloc_valid_1 || alloc_valid_2) && !alloc_ready) err_set = 1'b1;
        if (alloc_valid_2 && !alloc_valid_1)                  err_set = 1'b1;
        if (cmp_valid_0 && (!valid_q[cmp_idx_0] || cmpl_q[cmp_idx_0])) err_set = 1'b1;
        if (cmp_valid_1 && (!valid_q[cmp_idx_1] || cmpl_q[cmp_idx_1])) err_set = 1'b1;
        if (cmp_valid_2 && (!valid_q[cmp_idx_2] || cmpl_q[cmp_idx_2])) err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;

    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int AREG_W    = 5;
    localparam int PREG_W    = 6;

    logic              clk;
    logic              rst_n;
    logic              alloc_valid_1, alloc_valid_2;
    logic [AREG_W-1:0] alloc_rd_1, alloc_rd_2;
    logic [PREG_W-1:0] alloc_pd_1, alloc_pd_2;
    logic [PREG_W-1:0] alloc_old_pd_1, alloc_old_pd_2;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;
    logic              cmp_valid_0, cmp_valid_1, cmp_valid_2;
    logic [IDX_W-1:0]  cmp_idx_0, cmp_idx_1, cmp_idx_2;
    logic              ret_valid_1, ret_valid_2;
    logic [AREG_W-1:0] ret_rd_1, ret_rd_2;
    logic [PREG_W-1:0] ret_pd_1, ret_pd_2;
    logic              free_valid_1, free_valid_2;
    logic [PREG_W-1:0] free_pd_1, free_pd_2;
    logic [IDX_W:0]    count;
`ifdef ROB_RETIRE_CHECK_EN
    logic              err;
`endif

    rob_retire #(
        .ROB_DEPTH(ROB_DEPTH), .IDX_W(IDX_W), .AREG_W(AREG_W), .PREG_W(PREG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
        .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
        .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
        .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
        .alloc_ready(alloc_ready),
        .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .cmp_valid_0(cmp_valid_0), .cmp_valid_1(cmp_valid_1), .cmp_valid_2(cmp_valid_2),
        .cmp_idx_0(cmp_idx_0), .cmp_idx_1(cmp_idx_1), .cmp_idx_2(cmp_idx_2),
        .ret_valid_1(ret_valid_1), .ret_valid_2(ret_valid_2),
        .ret_rd_1(ret_rd_1), .ret_rd_2(ret_rd_2),
        .ret_pd_1(ret_pd_1), .ret_pd_2(ret_pd_2),
        .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
        .free_pd_1(free_pd_1), .free_pd_2(free_pd_2),
`ifdef ROB_RETIRE_CHECK_EN
        .err(err),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                slot;
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic              fv;
        logic [PREG_W-1:0] fpd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int slot, input int rd, input int pd, input bit fv, input int fpd);
        exp_t e;
        e.slot = slot;
        e.rd   = AREG_W'(rd);
        e.pd   = PREG_W'(pd);
        e.fv   = fv;
        e.fpd  = PREG_W'(fpd);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int slot, input logic [AREG_W-1:0] rd,
                           input logic [PREG_W-1:0] pd, input logic fv,
                           input logic [PREG_W-1:0] fpd);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire slot=%0d rd=%0d pd=%0d expected no retire", slot, rd, pd);
        end else begin
            e = exp_q.pop_front();
            chk("ret_slot", slot, e.slot);
            chk("ret_rd", rd, e.rd);
            chk("ret_pd", pd, e.pd);
            chk("free_valid", fv, e.fv);
            if (e.fv) chk("free_pd", fpd, e.fpd);
        end
    endtask

    // Monitor: consumes every retire pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ret_valid_2) chk("ret2_needs_ret1", ret_valid_1, 1);
            if (ret_valid_1) pop_cmp(1, ret_rd_1, ret_pd_1, free_valid_1, free_pd_1);
            if (ret_valid_2) pop_cmp(2, ret_rd_2, ret_pd_2, free_valid_2, free_pd_2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid_1 = 0; alloc_valid_2 = 0;
        alloc_rd_1 = 0; alloc_rd_2 = 0; alloc_pd_1 = 0; alloc_pd_2 = 0;
        alloc_old_pd_1 = 0; alloc_old_pd_2 = 0;
        cmp_valid_0 = 0; cmp_valid_1 = 0; cmp_valid_2 = 0;
        cmp_idx_0 = 0; cmp_idx_1 = 0; cmp_idx_2 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic alloc1(input int rd, input int pd, input int opd);
        alloc_valid_1 = 1; alloc_rd_1 = AREG_W'(rd); alloc_pd_1 = PREG_W'(pd); alloc_old_pd_1 = PREG_W'(opd);
        tick();
        alloc_valid_1 = 0;
    endtask

    task automatic alloc2(input int rd1, input int pd1, input int opd1,
                          input int rd2, input int pd2, input int opd2);
        alloc_valid_1 = 1; alloc_rd_1 = AREG_W'(rd1); alloc_pd_1 = PREG_W'(pd1); alloc_old_pd_1 = PREG_W'(opd1);
        alloc_valid_2 = 1; alloc_rd_2 = AREG_W'(rd2); alloc_pd_2 = PREG_W'(pd2); alloc_old_pd_2 = PREG_W'(opd2);
        tick();
        alloc_valid_1 = 0; alloc_valid_2 = 0;
    endtask

    task automatic cmp1(input int idx);
        cmp_valid_0 = 1; cmp_idx_0 = IDX_W'(idx);
        tick();
        cmp_valid_0 = 0;
    endtask

    task automatic cmp2(input int a, input int b);
        cmp_valid_0 = 1; cmp_idx_0 = IDX_W'(a);
        cmp_valid_1 = 1; cmp_idx_1 = IDX_W'(b);
        tick();
        cmp_valid_0 = 0; cmp_valid_1 = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d expected completion", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        clear_inputs();
        rst_n = 0;
        #3;
        // Reset state
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_idx_1", alloc_idx_1, 0);
        chk("rst_alloc_idx_2", alloc_idx_2, 1);
        chk("rst_ret_valid_1", ret_valid_1, 0);
        chk("rst_free_valid_1", free_valid_1, 0);
`ifdef ROB_RETIRE_CHECK_EN
        chk("rst_err", err, 0);
`endif
        tick();
        rst_n = 1;

        // Single alloc then complete: 2-edge latency
        chk("t1_alloc_idx_1", alloc_idx_1, 0);
        alloc1(3, 33, 3);
        chk("t1_count", count, 1);
        chk("t1_tail_adv", alloc_idx_1, 1);
        push_exp(1, 3, 33, 1, 3);
        cmp1(0);
        chk("t1_ret_not_yet", ret_valid_1, 0);
        tick();
        chk("t1_ret_valid_1", ret_valid_1, 1);
        chk("t1_count_after", count, 0);
        wait_drain("t1_drained");

        // Dual alloc; younger completes first, no retire until head completes
        do_reset();
        chk("t2_idx_1", alloc_idx_1, 0);
        chk("t2_idx_2", alloc_idx_2, 1);
        alloc2(5, 40, 10, 6, 41, 11);
        cmp1(1);
        tick(); tick(); tick();
        chk("t2_count_blocked", count, 2);
        push_exp(1, 5, 40, 1, 10);
        push_exp(2, 6, 41, 1, 11);
        cmp1(0);
        tick();
        chk("t2_both_ret_1", ret_valid_1, 1);
        chk("t2_both_ret_2", ret_valid_2, 1);
        wait_drain("t2_drained");

        // Fill to full, dropped alloc, retire two to reopen
        do_reset();
        for (int k = 0; k < 8; k++)
            alloc2(2*k+1, 2*k+20, 2*k+40, 2*k+2, 2*k+21, 2*k+41);
        chk("t3_count_full", count, 16);
        chk("t3_not_ready", alloc_ready, 0);
        alloc1(30, 63, 62);
        chk("t3_count_dropped", count, 16);
        chk("t3_tail_unchanged", alloc_idx_1, 0);
`ifdef ROB_RETIRE_CHECK_EN
        chk("t3_err", err, 1);
`endif
        push_exp(1, 1, 20, 1, 40);
        push_exp(2, 2, 21, 1, 41);
        cmp2(0, 1);
        chk("t3_still_not_ready", alloc_ready, 0);
        tick();
        chk("t3_count_14", count, 14);
        chk("t3_ready_again", alloc_ready, 1);
        wait_drain("t3_drained");

        // Wrap-around: walk head/tail to 15, then dual alloc across the wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            alloc1(i+1, 32+i, i+1);
            push_exp(1, i+1, 32+i, 1, i+1);
            cmp1(i);
        end
        wait_drain("t4_walk_drained");
        chk("t4_count_zero", count, 0);
        chk("t4_idx_1_15", alloc_idx_1, 15);
        chk("t4_idx_2_0", alloc_idx_2, 0);
        alloc2(7, 50, 20, 8, 51, 21);
        chk("t4_tail_wrapped", alloc_idx_1, 1);
        chk("t4_count_2", count, 2);
        push_exp(1, 7, 50, 1, 20);
        push_exp(2, 8, 51, 1, 21);
        cmp2(15, 0);
        wait_drain("t4_wrap_drained");
        chk("t4_count_end", count, 0);

        // x0 destination and zero stale mapping never free
        idx = int'(alloc_idx_1);
        alloc1(0, 0, 7);
        push_exp(1, 0, 0, 0, 0);
        cmp1(idx);
        wait_drain("t5_x0_drained");
        idx = int'(alloc_idx_1);
        alloc1(9, 44, 0);
        push_exp(1, 9, 44, 0, 0);
        cmp1(idx);
        wait_drain("t5_oldpd0_drained");

        // Reset mid-stream: 5 valid, 2 complete behind an incomplete head
        do_reset();
        alloc2(1, 10, 11, 2, 12, 13);
        alloc2(3, 14, 15, 4, 16, 17);
        alloc1(5, 18, 19);
        cmp2(1, 2);
        chk("t6_count_5", count, 5);
        #2;
        rst_n = 0;
        #1;
        chk("t6_count_async", count, 0);
        chk("t6_ready_async", alloc_ready, 1);
        chk("t6_idx_async", alloc_idx_1, 0);
        tick(); tick();
        rst_n = 1;
        cmp1(0);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_count_after", count, 0);
        chk("t6_no_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
